// File: rtl/wb_ram_burst.sv
// Wishbone B4 registered-feedback RAM slave with CTI/BTE bursts, range checking and
// read/write beat counters. Read wait states are fixed by RD_WAIT.
module wb_ram_burst #(
    parameter int unsigned dw        = 32,
    parameter int unsigned aw        = 32,
    parameter int unsigned MEM_WORDS = 8192,
    parameter int unsigned RD_WAIT   = 1
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_n_i,
    input  logic [aw-1:0]   wb_adr_i,
    input  logic [dw-1:0]   wb_dat_i,
    input  logic [dw/8-1:0] wb_sel_i,
    input  logic            wb_we_i,
    input  logic [1:0]      wb_bte_i,
    input  logic [2:0]      wb_cti_i,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    output logic            wb_ack_o,
    output logic            wb_err_o,
    output logic            wb_rty_o,
    output logic [dw-1:0]   wb_dat_o,
    output logic [31:0]     reads_o,
    output logic [31:0]     writes_o
);
    localparam int unsigned SW      = dw / 8;
    localparam int unsigned ADR_LSB = $clog2(SW);
    localparam int unsigned IW      = aw - ADR_LSB;
    localparam int unsigned MW      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_ERR} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d, nxt_idx, req_idx;
    logic            we_q, we_d;
    logic [1:0]      bte_q, bte_d;
    logic [3:0]      wait_q, wait_d;
    logic [dw-1:0]   rdata_q;
    logic [dw-1:0]   lane_mask;
    logic            beat, nxt_ok;
    logic [31:0]     reads_q, writes_q;
    logic [dw-1:0]   mem [MEM_WORDS];

    // Full-width compare so out-of-range addresses never alias into the array.
    function automatic logic in_range(input logic [IW-1:0] i);
        return 64'(i) < 64'(MEM_WORDS);
    endfunction

    if (ADR_LSB > 0) begin : g_lsb
        logic unused_lsb;
        assign unused_lsb = ^wb_adr_i[ADR_LSB-1:0];
    end

    assign req_idx = wb_adr_i[aw-1:ADR_LSB];
    assign beat    = (state_q == S_BURST) && wb_cyc_i && wb_stb_i;

    // Next burst index: wraps keep the upper bits, linear must not roll over the top.
    always_comb begin
        nxt_idx = idx_q + IW'(1);
        case (bte_q)
            2'b01:   nxt_idx = {idx_q[IW-1:2], idx_q[1:0] + 2'd1};
            2'b10:   nxt_idx = {idx_q[IW-1:3], idx_q[2:0] + 3'd1};
            2'b11:   nxt_idx = {idx_q[IW-1:4], idx_q[3:0] + 4'd1};
            default: ;
        endcase
        nxt_ok = in_range(nxt_idx) && !((bte_q == 2'b00) && (&idx_q));
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        we_d    = we_q;
        bte_d   = bte_q;
        wait_d  = wait_q;
        if (!wb_cyc_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (wb_stb_i) begin
                        idx_d = req_idx;
                        we_d  = wb_we_i;
                        bte_d = wb_bte_i;
                        if (!in_range(req_idx)) begin
                            state_d = S_ERR;
                        end else if (wb_we_i || (RD_WAIT == 0)) begin
                            state_d = S_BURST;
                        end else begin
                            state_d = S_WAIT;
                            wait_d  = 4'(RD_WAIT - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_q == 4'd0) state_d = S_BURST;
                    else                wait_d  = wait_q - 4'd1;
                end
                S_BURST: begin
                    if (wb_stb_i) begin
                        if (wb_cti_i == 3'b010) begin
                            if (nxt_ok) idx_d   = nxt_idx;
                            else        state_d = S_ERR;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_ERR:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            we_q     <= 1'b0;
            bte_q    <= 2'b00;
            wait_q   <= 4'd0;
            reads_q  <= 32'd0;
            writes_q <= 32'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            bte_q   <= bte_d;
            wait_q  <= wait_d;
            if (beat && we_q)  writes_q <= writes_q + 32'd1;
            if (beat && !we_q) reads_q  <= reads_q + 32'd1;
        end
    end

    // Array is not reset; the read port prefetches the word the next cycle will present.
    always_ff @(posedge wb_clk_i) begin
        if (beat && we_q) begin
            for (int unsigned i = 0; i < SW; i++) begin
                if (wb_sel_i[i]) mem[idx_q[MW-1:0]][8*i +: 8] <= wb_dat_i[8*i +: 8];
            end
        end
        if (in_range(idx_d)) rdata_q <= mem[idx_d[MW-1:0]];
    end

    always_comb begin
        lane_mask = '0;
        for (int unsigned i = 0; i < SW; i++) lane_mask[8*i +: 8] = {8{wb_sel_i[i]}};
    end

    assign wb_ack_o = beat;
    assign wb_err_o = (state_q == S_ERR) && wb_cyc_i && wb_stb_i;
    assign wb_rty_o = 1'b0;
    assign wb_dat_o = (beat && !we_q) ? (rdata_q & lane_mask) : '0;
    assign reads_o  = reads_q;
    assign writes_o = writes_q;

endmodule

// File: tb/tb_wb_ram_burst.sv
// Scoreboarded bench for wb_ram_burst: directed Wishbone transfers push expected
// responses, a negedge monitor pops and compares type, cycle and read data.
module tb_wb_ram_burst;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] adr, dat_i, dat_o, reads, writes;
    logic [3:0]  sel;
    logic        we, cyc, stb, ack, err, rty;
    logic [1:0]  bte;
    logic [2:0]  cti;

    typedef struct {
        bit          is_err;
        bit          chk_dat;
        logic [31:0] dat;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_cnt = 0;

    wb_ram_burst #(.dw(32), .aw(32), .MEM_WORDS(64), .RD_WAIT(1)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_i),
        .wb_sel_i(sel), .wb_we_i(we), .wb_bte_i(bte), .wb_cti_i(cti),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_ack_o(ack), .wb_err_o(err),
        .wb_rty_o(rty), .wb_dat_o(dat_o), .reads_o(reads), .writes_o(writes)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc_cnt++;
    end

    // Monitor: every ack/err must match the oldest outstanding expectation.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (ack || err) begin
            checks++;
            if (ack && err) begin
                errors++;
                $display("FAIL ack_err_both ack=%0b err=%0b cycle=%0d", ack, err, cyc_cnt);
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp ack=%0b err=%0b cycle=%0d", ack, err, cyc_cnt);
            end else begin
                e = sb.pop_front();
                if (err != e.is_err) begin
                    errors++;
                    $display("FAIL resp_type got err=%0b want err=%0b cycle=%0d", err, e.is_err, cyc_cnt);
                end
                checks++;
                if (cyc_cnt != e.cyc) begin
                    errors++;
                    $display("FAIL resp_cycle got %0d want %0d", cyc_cnt, e.cyc);
                end
                if (e.chk_dat) begin
                    checks++;
                    if (dat_o !== e.dat) begin
                        errors++;
                        $display("FAIL read_data got %08h want %08h cycle=%0d", dat_o, e.dat, cyc_cnt);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %08h want %08h", name, act, exp);
        end
    endtask

    // One beat: push expectation, drive, wait (bounded) for ack/err, step past the edge.
    task automatic beat(input logic [31:0] a, input bit w, input logic [31:0] d,
                        input logic [3:0] s, input logic [2:0] c, input logic [1:0] b,
                        input bit exp_err, input logic [31:0] exp_dat, input int lat);
        exp_t e;
        bit   got = 0;
        e.is_err  = exp_err;
        e.chk_dat = !w && !exp_err;
        e.dat     = exp_dat;
        e.cyc     = cyc_cnt + lat;
        sb.push_back(e);
        adr = a; we = w; dat_i = d; sel = s; cti = c; bte = b;
        cyc = 1'b1; stb = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack || err) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout adr=%08h got no response want ack/err", a);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        cyc = 1'b0; stb = 1'b0; cti = 3'b000;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        stb = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        adr = '0; dat_i = '0; sel = '0; we = 1'b0; bte = '0; cti = '0; cyc = 1'b0; stb = 1'b0;
        #3;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rty", 32'(rty), 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_reads", reads, 32'd0);
        chk("rst_writes", writes, 32'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Classic write then classic read
        beat(32'h10, 1, 32'hDEADBEEF, 4'hF, 3'b000, 2'b00, 0, 32'h0, 1);
        idle(1);
        beat(32'h10, 0, 32'h0, 4'hF, 3'b000, 2'b00, 0, 32'hDEADBEEF, 2);
        idle(1);
        chk("t1_writes", writes, 32'd1);
        chk("t1_reads", reads, 32'd1);

        // Byte-lane writes and lane-masked reads
        beat(32'h20, 1, 32'h11223344, 4'hF, 3'b000, 2'b00, 0, 32'h0, 1);
        idle(1);
        beat(32'h20, 1, 32'hAABBCCDD, 4'b0101, 3'b000, 2'b00, 0, 32'h0, 1);
        idle(1);
        beat(32'h20, 0, 32'h0, 4'hF, 3'b000, 2'b00, 0, 32'h11BB33DD, 2);
        idle(1);
        beat(32'h20, 0, 32'h0, 4'b0011, 3'b000, 2'b00, 0, 32'h000033DD, 2);
        idle(1);
        chk("t2_writes", writes, 32'd3);
        chk("t2_reads", reads, 32'd3);

        // Prefill 0x30..0x3C, then wrap4 read burst from 0x38
        beat(32'h30, 1, 32'hA0A0A0A0, 4'hF, 3'b010, 2'b00, 0, 32'h0, 1);
        beat(32'h34, 1, 32'hA1A1A1A1, 4'hF, 3'b010, 2'b00, 0, 32'h0, 0);
        beat(32'h38, 1, 32'hA2A2A2A2, 4'hF, 3'b010, 2'b00, 0, 32'h0, 0);
        beat(32'h3C, 1, 32'hA3A3A3A3, 4'hF, 3'b111, 2'b00, 0, 32'h0, 0);
        idle(1);
        beat(32'h38, 0, 32'h0, 4'hF, 3'b010, 2'b01, 0, 32'hA2A2A2A2, 2);
        beat(32'h3C, 0, 32'h0, 4'hF, 3'b010, 2'b01, 0, 32'hA3A3A3A3, 0);
        beat(32'h30, 0, 32'h0, 4'hF, 3'b010, 2'b01, 0, 32'hA0A0A0A0, 0);
        beat(32'h34, 0, 32'h0, 4'hF, 3'b111, 2'b01, 0, 32'hA1A1A1A1, 0);
        idle(1);
        chk("t3_writes", writes, 32'd7);
        chk("t3_reads", reads, 32'd7);

        // Linear write burst with a 2-cycle master wait after beat 2
        beat(32'h80, 1, 32'hB0B0B0B0, 4'hF, 3'b010, 2'b00, 0, 32'h0, 1);
        beat(32'h84, 1, 32'hB1B1B1B1, 4'hF, 3'b010, 2'b00, 0, 32'h0, 0);
        gap(2);
        beat(32'h88, 1, 32'hB2B2B2B2, 4'hF, 3'b010, 2'b00, 0, 32'h0, 0);
        beat(32'h8C, 1, 32'hB3B3B3B3, 4'hF, 3'b111, 2'b00, 0, 32'h0, 0);
        idle(1);
        chk("t4_writes_after_gap", writes, 32'd11);
        beat(32'h80, 0, 32'h0, 4'hF, 3'b010, 2'b00, 0, 32'hB0B0B0B0, 2);
        beat(32'h84, 0, 32'h0, 4'hF, 3'b010, 2'b00, 0, 32'hB1B1B1B1, 0);
        beat(32'h88, 0, 32'h0, 4'hF, 3'b010, 2'b00, 0, 32'hB2B2B2B2, 0);
        beat(32'h8C, 0, 32'h0, 4'hF, 3'b111, 2'b00, 0, 32'hB3B3B3B3, 0);
        idle(1);
        chk("t4_reads", reads, 32'd11);

        // Out-of-range single access and a linear burst running off the end
        beat(32'h100, 0, 32'h0, 4'hF, 3'b000, 2'b00, 1, 32'h0, 1);
        idle(1);
        chk("t5_reads_after_err", reads, 32'd11);
        beat(32'hF8, 1, 32'hC0C0C0C0, 4'hF, 3'b010, 2'b00, 0, 32'h0, 1);
        beat(32'hFC, 1, 32'hC1C1C1C1, 4'hF, 3'b010, 2'b00, 0, 32'h0, 0);
        beat(32'h100, 1, 32'hC2C2C2C2, 4'hF, 3'b111, 2'b00, 1, 32'h0, 0);
        idle(1);
        chk("t5_writes", writes, 32'd13);
        beat(32'hFC, 0, 32'h0, 4'hF, 3'b000, 2'b00, 0, 32'hC1C1C1C1, 2);
        idle(1);
        chk("t5_reads", reads, 32'd12);

        // Reset mid-burst
        beat(32'h10, 0, 32'h0, 4'hF, 3'b010, 2'b00, 0, 32'hDEADBEEF, 2);
        chk("t6_pre_reset_ack", 32'(ack), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_ack", 32'(ack), 32'd0);
        chk("t6_rst_dat", dat_o, 32'd0);
        chk("t6_rst_reads", reads, 32'd0);
        chk("t6_rst_writes", writes, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        beat(32'h40, 1, 32'h12345678, 4'hF, 3'b000, 2'b00, 0, 32'h0, 1);
        idle(1);
        beat(32'h40, 0, 32'h0, 4'hF, 3'b000, 2'b00, 0, 32'h12345678, 2);
        idle(1);
        beat(32'h80, 0, 32'h0, 4'hF, 3'b000, 2'b00, 0, 32'hB0B0B0B0, 2);
        idle(2);
        chk("t6_writes", writes, 32'd1);
        chk("t6_reads", reads, 32'd2);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
